regfile_wb_queue: RTL and testbench

- Write-back buffer that sits in front of the write port of the 32x32 `regfile`.
- Accepts register write requests from execution units over a valid/ready handshake and holds them in a FIFO of DEPTH entries.
- Drains one entry per granted cycle into the regfile's `wr_en`/`wr_addr`/`wr_data` port.
- Supplies bypass data on both read-address ports, so readers see pending writes before they land in the regfile.

---
 rtl/regfile_wb_queue.sv | 102 ++++++++++
 tb/tb_regfile_wb_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the regfile write port: FIFO of pending register
// writes with youngest-match bypass on both read ports.
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     wr_gnt,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  input  logic [AW-1:0]            rd_addrA,
  input  logic [AW-1:0]            rd_addrB,
  output logic                     byp_hitA,
  output logic [DW-1:0]            byp_dataA,
  output logic                     byp_hitB,
  output logic [DW-1:0]            byp_dataB,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];

  logic full, empty, accept, push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  // Writes to register 0 complete the handshake but never occupy an entry.
  assign push     = accept && (in_addr != '0);
  assign wr_en    = !empty && wr_gnt;
  assign pop      = wr_en;
  assign count    = count_q;
  assign wr_addr  = empty ? '0 : addr_q[head_q];
  assign wr_data  = empty ? '0 : data_q[head_q];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        head_q          <= head_q + PW'(1);
        valid_q[head_q] <= 1'b0;
      end
      if (push) begin
        tail_q          <= tail_q + PW'(1);
        valid_q[tail_q] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage is qualified by valid_q/count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    byp_hitA  = 1'b0;
    byp_dataA = '0;
    byp_hitB  = 1'b0;
    byp_dataB = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && (rd_addrA != '0) && (addr_q[idx] == rd_addrA)) begin
        byp_hitA  = 1'b1;
        byp_dataA = data_q[idx];
      end
      if (valid_q[idx] && (rd_addrB != '0) && (addr_q[idx] == rd_addrB)) begin
        byp_hitB  = 1'b1;
        byp_dataB = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a behavioural regfile that records
// every write the queue issues.
module tb_regfile_wb_queue;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          nrst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wr_gnt;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addrA, rd_addrB;
  logic          byp_hitA, byp_hitB;
  logic [DW-1:0] byp_dataA, byp_dataB;
  logic [2:0]    count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [DW-1:0]    rf [32];
  logic [AW+DW-1:0] wlog [$];

  regfile_wb_queue #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wr_gnt(wr_gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .byp_hitA(byp_hitA), .byp_dataA(byp_dataA),
    .byp_hitB(byp_hitB), .byp_dataB(byp_dataB),
    .count(count)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) rf[i] = '0;

  always @(posedge clk) begin
    if (nrst && wr_en) begin
      wlog.push_back({wr_addr, wr_data});
      if (wr_addr != '0) rf[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] fill_addr [4] = '{5'd3, 5'd3, 5'd4, 5'd5};
  logic [DW-1:0] fill_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    nrst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    wr_gnt = 1'b1; rd_addrA = '0; rd_addrB = '0;
    #2;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_hitA", byp_hitA, 0);
    tick(); tick();
    nrst = 1'b1;

    // Idle with grant available
    rd_addrA = 5'd1; rd_addrB = 5'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_count", count, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_wr_en", wr_en, 0);
      check("idle_hitA", byp_hitA, 0);
      check("idle_hitB", byp_hitB, 0);
    end

    // Single push, drains one cycle after accept
    in_valid = 1'b1; in_addr = 5'd1; in_data = 32'hDEADBEEF;
    #1;
    check("p1_ready", in_ready, 1);
    check("p1_no_early_wr", wr_en, 0);
    check("p1_no_early_hit", byp_hitA, 0);
    tick();
    in_valid = 1'b0;
    #1;
    check("p1_count", count, 1);
    check("p1_wr_en", wr_en, 1);
    check("p1_wr_addr", wr_addr, 1);
    check("p1_wr_data", wr_data, 32'hDEADBEEF);
    check("p1_hitA", byp_hitA, 1);
    check("p1_dataA", byp_dataA, 32'hDEADBEEF);
    tick();
    check("p1_count_after", count, 0);
    check("p1_wr_en_after", wr_en, 0);
    check("p1_nwrites", wlog.size(), 1);
    check("p1_rf", rf[1], 32'hDEADBEEF);
    wlog.delete();

    // Fill with grant held low (pointers wrap from 1)
    wr_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = fill_addr[i]; in_data = fill_data[i];
      tick();
      check("fill_count", count, i + 1);
    end
    check("full_ready", in_ready, 0);
    in_addr = 5'd7; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    check("full_count_hold", count, 4);
    check("full_no_wr", wr_en, 0);
    rd_addrA = 5'd3; rd_addrB = 5'd6;
    #1;
    check("full_hitA", byp_hitA, 1);
    check("full_dataA_youngest", byp_dataA, 32'h22);
    check("full_hitB", byp_hitB, 0);
    check("full_dataB", byp_dataB, 0);
    rd_addrB = 5'd4;
    #1;
    check("full_hitB4", byp_hitB, 1);
    check("full_dataB4", byp_dataB, 32'h33);
    rd_addrB = 5'd5;
    #1;
    check("full_dataB5", byp_dataB, 32'h44);

    // Drain from full
    wr_gnt = 1'b1;
    #1;
    check("dr0_wr_en", wr_en, 1);
    check("dr0_addr", wr_addr, 3);
    check("dr0_data", wr_data, 32'h11);
    check("dr0_ready", in_ready, 0);
    tick();
    check("dr1_ready", in_ready, 1);
    check("dr1_count", count, 3);
    check("dr1_data", wr_data, 32'h22);
    check("dr1_hitA", byp_hitA, 1);
    check("dr1_dataA", byp_dataA, 32'h22);
    tick(); tick();
    check("dr3_count", count, 1);
    check("dr3_addr", wr_addr, 5);
    tick();
    check("dr_done_count", count, 0);
    check("dr_done_wr_en", wr_en, 0);
    check("dr_done_hitA", byp_hitA, 0);
    check("dr_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check("dr_order", wlog[i], {fill_addr[i], fill_data[i]});
    check("dr_rf3", rf[3], 32'h22);
    check("dr_rf4", rf[4], 32'h33);
    check("dr_rf5", rf[5], 32'h44);
    check("dr_rf7_rejected", rf[7], 0);
    wlog.delete();

    // Register 0 write is accepted and dropped
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFFFFFF;
    rd_addrA = 5'd0;
    #1;
    check("z_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("z_count", count, 0);
    check("z_wr_en", wr_en, 0);
    check("z_hitA", byp_hitA, 0);
    tick();
    check("z_nwrites", wlog.size(), 0);

    // Simultaneous accept and drain keeps count
    in_valid = 1'b1; in_addr = 5'd8; in_data = 32'hA;
    tick();
    in_addr = 5'd9; in_data = 32'hB;
    #1;
    check("sim_wr_en", wr_en, 1);
    tick();
    in_valid = 1'b0;
    check("sim_count", count, 1);
    check("sim_head", wr_addr, 9);
    tick();
    check("sim_empty", count, 0);
    check("sim_nwrites", wlog.size(), 2);
    wlog.delete();

    // Fill 3 then asynchronous reset mid-cycle
    wr_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 5'(10 + i); in_data = 32'(100 + i);
      tick();
    end
    in_valid = 1'b0;
    rd_addrA = 5'd10; rd_addrB = 5'd12;
    #1;
    check("pre_rst_count", count, 3);
    check("pre_rst_hitA", byp_hitA, 1);
    check("pre_rst_dataB", byp_dataB, 102);
    #2;
    nrst = 1'b0; wr_gnt = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_hitA", byp_hitA, 0);
    check("arst_hitB", byp_hitB, 0);
    check("arst_dataB", byp_dataB, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_ready", in_ready, 1);
    tick();
    nrst = 1'b1;
    tick(); tick();
    check("arst_nwrites", wlog.size(), 0);
    check("arst_rf10", rf[10], 0);
    check("arst_count_after", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
